// File: rtl/dmac_channel_datapath_gen2.sv
// DMA channel datapath: address/beat/burst counters plus FWFT data FIFO, all outputs combinational from registers.
// No backpressure of its own: the FSM qualifies rd_beat/wr_beat; overflow drops data and underflow is ignored, both flag err.
module dmac_channel_datapath_gen2 #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [ADDR_W-1:0]             cfg_src_addr,
    input  logic [ADDR_W-1:0]             cfg_dst_addr,
    input  logic [CNT_W-1:0]              cfg_xfer_beats,
    input  logic [4:0]                    cfg_burst_len,
    input  logic [1:0]                    cfg_hsize,
    input  logic                          cfg_src_fixed,
    input  logic                          cfg_dst_fixed,
    input  logic                          burst_start,
    input  logic                          rd_beat,
    input  logic [DATA_W-1:0]             r_data,
    input  logic                          wr_beat,
    input  logic                          h_sel,
    input  logic                          trigger,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    output logic [1:0]                    m_burst,
    output logic                          rd_burst_last,
    output logic                          wr_burst_last,
    output logic [CNT_W-1:0]              beats_left,
    output logic                          xfer_done,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    logic [ADDR_W-1:0] src_addr, dst_addr, step;
    logic [1:0]        hsize_q, len_q, eff_q;
    logic              src_fixed_q, dst_fixed_q;
    logic [4:0]        rd_cnt, wr_cnt, eff_beats, len_beats, last_idx;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              do_push, do_pop, misaligned;
    logic [LANE_W-1:0] lane;
    logic [3:0]        size_bytes;
    logic [15:0]       strb_mask, strb_wide;

    // Burst length is held as the 2-bit bus encoding; beat count derived on demand.
    function automatic logic [4:0] enc_beats(input logic [1:0] e);
        case (e)
            2'd1:    return 5'd4;
            2'd2:    return 5'd8;
            2'd3:    return 5'd16;
            default: return 5'd1;
        endcase
    endfunction

    assign eff_beats = enc_beats(eff_q);
    assign len_beats = enc_beats(len_q);
    assign last_idx  = eff_beats - 5'd1;
    assign step      = {{(ADDR_W-1){1'b0}}, 1'b1} << hsize_q;

    assign m_addr        = h_sel ? dst_addr : src_addr;
    assign m_burst       = eff_q;
    assign rd_burst_last = (rd_cnt == last_idx);
    assign wr_burst_last = (wr_cnt == last_idx);
    assign fifo_level    = level;
    assign fifo_full     = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty    = (level == '0);

    assign do_pop  = wr_beat && !fifo_empty;
    assign do_push = rd_beat && (!fifo_full || do_pop);

    assign lane       = dst_addr[LANE_W-1:0];
    assign size_bytes = 4'd1 << hsize_q;
    assign misaligned = ((4'(lane) & (size_bytes - 4'd1)) != 4'd0);
    assign strb_mask  = (16'd1 << size_bytes) - 16'd1;
    assign strb_wide  = strb_mask << lane;

    assign m_wdata = trigger ? mem[rd_ptr] : '0;
    assign m_wstrb = (trigger && !misaligned) ? strb_wide[STRB_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_addr    <= '0;
            dst_addr    <= '0;
            beats_left  <= '0;
            hsize_q     <= '0;
            len_q       <= '0;
            eff_q       <= '0;
            src_fixed_q <= 1'b0;
            dst_fixed_q <= 1'b0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            xfer_done   <= 1'b0;
            err         <= 1'b0;
        end else if (cfg_load) begin
            src_addr    <= cfg_src_addr;
            dst_addr    <= cfg_dst_addr;
            beats_left  <= cfg_xfer_beats;
            hsize_q     <= cfg_hsize;
            src_fixed_q <= cfg_src_fixed;
            dst_fixed_q <= cfg_dst_fixed;
            case (cfg_burst_len)
                5'd4:    len_q <= 2'd1;
                5'd8:    len_q <= 2'd2;
                5'd16:   len_q <= 2'd3;
                default: len_q <= 2'd0;
            endcase
            eff_q     <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            xfer_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (burst_start) begin
                // Tail shorter than a full burst is moved as single beats.
                eff_q  <= (beats_left >= CNT_W'(len_beats)) ? len_q : 2'd0;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_beat) rd_cnt <= rd_cnt + 5'd1;
                if (wr_beat) wr_cnt <= wr_cnt + 5'd1;
            end
            if (rd_beat && !src_fixed_q) src_addr <= src_addr + step;
            if (wr_beat && !dst_fixed_q) dst_addr <= dst_addr + step;
            if (wr_beat && beats_left != '0) begin
                beats_left <= beats_left - CNT_W'(1);
                if (beats_left == CNT_W'(1)) xfer_done <= 1'b1;
            end
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
            if ((rd_beat && !do_push) || (wr_beat && fifo_empty) ||
                (wr_beat && beats_left == '0) || (wr_beat && misaligned))
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (!cfg_load && do_push) begin
            mem[wr_ptr] <= r_data;
        end
    end
endmodule

// File: tb/tb_dmac_channel_datapath_gen2.sv
// Bench for the DMA channel datapath: queue-based reference model plus directed scenarios with literal expectations.
module tb_dmac_channel_datapath_gen2;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load, cfg_src_fixed, cfg_dst_fixed;
    logic [31:0] cfg_src_addr, cfg_dst_addr;
    logic [15:0] cfg_xfer_beats;
    logic [4:0]  cfg_burst_len;
    logic [1:0]  cfg_hsize;
    logic        burst_start, rd_beat, wr_beat, h_sel, trigger;
    logic [31:0] r_data;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_burst;
    logic        rd_burst_last, wr_burst_last, xfer_done, fifo_full, fifo_empty, err;
    logic [15:0] beats_left;
    logic [4:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    dmac_channel_datapath_gen2 dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load),
        .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
        .cfg_xfer_beats(cfg_xfer_beats), .cfg_burst_len(cfg_burst_len),
        .cfg_hsize(cfg_hsize), .cfg_src_fixed(cfg_src_fixed), .cfg_dst_fixed(cfg_dst_fixed),
        .burst_start(burst_start), .rd_beat(rd_beat), .r_data(r_data),
        .wr_beat(wr_beat), .h_sel(h_sel), .trigger(trigger),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_burst(m_burst),
        .rd_burst_last(rd_burst_last), .wr_burst_last(wr_burst_last),
        .beats_left(beats_left), .xfer_done(xfer_done), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transfer state as plain numbers, FIFO as a queue.
    logic [31:0] ms, md;
    int          mb, mlen, mhs, meff, mrc, mwc, old_b, qn;
    bit          msf, mdf, mdone, merr, was_misal, pop_ok;
    logic [31:0] mq[$];

    function automatic bit model_misal();
        int bytes = 1 << mhs;
        return (int'(md[1:0]) % bytes) != 0;
    endfunction

    function automatic logic [3:0] model_strb();
        int bytes = 1 << mhs;
        if (model_misal()) return 4'h0;
        return 4'(((1 << bytes) - 1) << int'(md[1:0]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms = 0; md = 0; mb = 0; mlen = 1; mhs = 0; msf = 0; mdf = 0;
            meff = 1; mrc = 0; mwc = 0; mdone = 0; merr = 0; mq.delete();
        end else if (cfg_load) begin
            ms = cfg_src_addr; md = cfg_dst_addr; mb = int'(cfg_xfer_beats);
            mlen = (cfg_burst_len inside {5'd4, 5'd8, 5'd16}) ? int'(cfg_burst_len) : 1;
            mhs = int'(cfg_hsize); msf = cfg_src_fixed; mdf = cfg_dst_fixed;
            meff = 1; mrc = 0; mwc = 0; mdone = 0; merr = 0; mq.delete();
        end else begin
            old_b = mb; was_misal = model_misal(); qn = mq.size();
            pop_ok = wr_beat && qn > 0;
            if (wr_beat && qn == 0) merr = 1;
            if (rd_beat && qn == 16 && !pop_ok) merr = 1;
            if (pop_ok) void'(mq.pop_front());
            if (rd_beat && !(qn == 16 && !pop_ok)) mq.push_back(r_data);
            if (wr_beat) begin
                if (old_b == 0) merr = 1;
                else begin
                    if (old_b == 1) mdone = 1;
                    mb = old_b - 1;
                end
                if (was_misal) merr = 1;
                if (!mdf) md = md + (1 << mhs);
            end
            if (rd_beat && !msf) ms = ms + (1 << mhs);
            if (burst_start) begin
                meff = (old_b >= mlen) ? mlen : 1;
                mrc = 0; mwc = 0;
            end else begin
                if (rd_beat) mrc = (mrc + 1) % 32;
                if (wr_beat) mwc = (mwc + 1) % 32;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_addr", m_addr, h_sel ? md : ms);
        chk("m_wstrb", m_wstrb, trigger ? model_strb() : 4'h0);
        if (!trigger) chk("m_wdata_idle", m_wdata, 0);
        else if (mq.size() > 0) chk("m_wdata", m_wdata, mq[0]);
        chk("m_burst", m_burst, meff == 16 ? 3 : meff == 8 ? 2 : meff == 4 ? 1 : 0);
        chk("rd_burst_last", rd_burst_last, mrc == meff - 1);
        chk("wr_burst_last", wr_burst_last, mwc == meff - 1);
        chk("beats_left", beats_left, mb);
        chk("xfer_done", xfer_done, mdone);
        chk("fifo_level", fifo_level, mq.size());
        chk("fifo_full", fifo_full, mq.size() == 16);
        chk("fifo_empty", fifo_empty, mq.size() == 0);
        chk("err", err, merr);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] s, input logic [31:0] d, input logic [15:0] b,
                        input logic [4:0] bl, input logic [1:0] hs, input logic sf, input logic df);
        cfg_src_addr = s; cfg_dst_addr = d; cfg_xfer_beats = b; cfg_burst_len = bl;
        cfg_hsize = hs; cfg_src_fixed = sf; cfg_dst_fixed = df; cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic rd(input logic [31:0] d);
        rd_beat = 1'b1; r_data = d;
        step();
        rd_beat = 1'b0;
    endtask

    task automatic wr();
        wr_beat = 1'b1; trigger = 1'b1; h_sel = 1'b1;
        step();
        wr_beat = 1'b0;
    endtask

    task automatic bstart();
        burst_start = 1'b1;
        step();
        burst_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_load = 0; cfg_src_addr = 0; cfg_dst_addr = 0; cfg_xfer_beats = 0;
        cfg_burst_len = 0; cfg_hsize = 0; cfg_src_fixed = 0; cfg_dst_fixed = 0;
        burst_start = 0; rd_beat = 0; wr_beat = 0; h_sel = 0; trigger = 0; r_data = 0;
        step(); step();
        chk("rst_empty", fifo_empty, 1); chk("rst_full", fifo_full, 0);
        chk("rst_burst", m_burst, 2'b00); chk("rst_wdata", m_wdata, 0);
        chk("rst_wstrb", m_wstrb, 0); chk("rst_done", xfer_done, 0); chk("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Eight words in, eight out, two bursts of four.
        load(32'h100, 32'h200, 16'd8, 5'd4, 2'd2, 1'b0, 1'b0);
        chk("t1_beats", beats_left, 8); chk("t1_src", m_addr, 32'h100);
        bstart();
        chk("t1_burst", m_burst, 2'b01);
        for (int i = 0; i < 8; i++) rd(32'hA0 + i);
        chk("t1_src_end", m_addr, 32'h120); chk("t1_level", fifo_level, 8);
        trigger = 1'b1; h_sel = 1'b1; #1;
        chk("t1_head", m_wdata, 32'hA0); chk("t1_dst", m_addr, 32'h200); chk("t1_strb", m_wstrb, 4'hF);
        for (int b = 0; b < 2; b++) begin
            bstart();
            for (int i = 0; i < 4; i++) begin
                if (b == 1 && i == 3) chk("t1_done_early", xfer_done, 0);
                wr();
            end
        end
        chk("t1_done", xfer_done, 1); chk("t1_left", beats_left, 0);
        chk("t1_dst_end", m_addr, 32'h220); chk("t1_empty", fifo_empty, 1);
        trigger = 1'b0; h_sel = 1'b0;

        // Six beats with burst 4: one full burst then singles.
        load(32'h0, 32'h400, 16'd6, 5'd4, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) rd(32'hB0 + i);
        bstart();
        chk("t2_burst4", m_burst, 2'b01);
        for (int i = 0; i < 4; i++) wr();
        chk("t2_left", beats_left, 2);
        for (int i = 0; i < 2; i++) begin
            bstart();
            chk("t2_single", m_burst, 2'b00);
            wr();
        end
        chk("t2_done", xfer_done, 1);
        trigger = 1'b0;

        // Fixed byte destination at lane 3.
        load(32'h100, 32'h203, 16'd4, 5'd1, 2'd0, 1'b0, 1'b1);
        rd(32'hC0);
        trigger = 1'b1; h_sel = 1'b1; #1;
        chk("t3_strb", m_wstrb, 4'b1000);
        wr();
        chk("t3_dst_hold", m_addr, 32'h203); chk("t3_err", err, 0);
        trigger = 1'b0;

        // Misaligned halfword.
        load(32'h100, 32'h201, 16'd4, 5'd1, 2'd1, 1'b0, 1'b0);
        rd(32'hD0);
        trigger = 1'b1; h_sel = 1'b1; #1;
        chk("t4_strb", m_wstrb, 4'b0000);
        wr();
        chk("t4_err", err, 1);
        trigger = 1'b0;

        // Overflow, then simultaneous push and pop while full.
        load(32'h0, 32'h0, 16'd32, 5'd16, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) rd(32'h5000 + i);
        chk("t5_level", fifo_level, 16); chk("t5_full", fifo_full, 1); chk("t5_err", err, 1);
        rd_beat = 1'b1; r_data = 32'h6000; wr_beat = 1'b1; trigger = 1'b1; h_sel = 1'b1;
        step();
        rd_beat = 1'b0; wr_beat = 1'b0;
        chk("t5_level_pp", fifo_level, 16); chk("t5_head_pp", m_wdata, 32'h5001);
        trigger = 1'b0;

        // Asynchronous reset with a full FIFO.
        rst = 1'b1; #1;
        chk("t6_rst_empty", fifo_empty, 1); chk("t6_rst_level", fifo_level, 0); chk("t6_rst_err", err, 0);
        step();
        rst = 1'b0;
        step();

        // Reload mid-burst with five words queued and err set.
        load(32'h100, 32'h202, 16'd16, 5'd8, 2'd2, 1'b0, 1'b0);
        bstart();
        for (int i = 0; i < 6; i++) rd(32'hE0 + i);
        wr();
        chk("t7_level", fifo_level, 5); chk("t7_err_pre", err, 1);
        h_sel = 1'b0; trigger = 1'b0;
        load(32'h800, 32'h900, 16'd4, 5'd4, 2'd2, 1'b0, 1'b0);
        chk("t7_empty", fifo_empty, 1); chk("t7_err", err, 0); chk("t7_src", m_addr, 32'h800);

        // Write beat with nothing left to move.
        load(32'h0, 32'h0, 16'd0, 5'd1, 2'd2, 1'b0, 1'b0);
        rd(32'hF0);
        wr();
        chk("t8_left", beats_left, 0); chk("t8_err", err, 1); chk("t8_done", xfer_done, 0);
        trigger = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
